// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: core (port 0) wins by default,
// the loader (port 1) is forced through after STARVE_LIMIT consecutive core wins; reads return via a tag pipeline.
module dmem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt;
  logic [3:0]        starve_nxt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_issue;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_port;

  // Grants are masked while in reset so the memory stays idle even with requests held.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        if (starve_cnt == LIMIT) m1_gnt = 1'b1;
        else                     m0_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!m1_req || m1_gnt)
      starve_nxt = 4'd0;
    else if (m0_gnt && starve_cnt != LIMIT)
      starve_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= 4'd0;
    else        starve_cnt <= starve_nxt;
  end

  assign any_gnt   = m0_gnt | m1_gnt;
  assign sel_we    = m1_gnt ? m1_we    : m0_we;
  assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign rd_issue  = any_gnt & ~sel_we;

  assign CEN      = ~any_gnt;
  assign WEN      = ~(any_gnt & sel_we);
  assign OEN      = ~rd_issue;
  assign A        = any_gnt ? sel_addr : '0;
  assign Data2Mem = (any_gnt && sel_we) ? sel_wdata : '0;

  // Tag pipeline: one stage per cycle of memory read latency, so the exiting tag lines up with ReadDataMem.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld  <= '0;
      tag_port <= '0;
    end else begin
      tag_vld[0]  <= rd_issue;
      tag_port[0] <= m1_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_port[i] <= tag_port[i-1];
      end
    end
  end

  assign m0_rvalid = tag_vld[RD_LAT-1] & ~tag_port[RD_LAT-1];
  assign m1_rvalid = tag_vld[RD_LAT-1] &  tag_port[RD_LAT-1];
  assign m0_rdata  = m0_rvalid ? ReadDataMem : '0;
  assign m1_rdata  = m1_rvalid ? ReadDataMem : '0;

endmodule
